// File: rtl/frame_deser.sv
// frame_deser: frame synchroniser and deserialiser for the r_fsk bitstream.
// Hunts for SYNC_WORD, shifts in a DATA_W-bit payload MSB-first, presents it
// with a one-cycle data_valid pulse and re-checks the sync word between frames.
// Optional macro FRAME_PARITY_EN adds an even-parity bit after each payload
// and the parity_err output.
module frame_deser #(
  parameter int                DATA_W    = 16,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              sync_err
`ifdef FRAME_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int HW = $clog2(SYNC_W + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [HW-1:0] SYNC_LAST = HW'(SYNC_W - 1);
  localparam logic [HW-1:0] SYNC_FULL = HW'(SYNC_W);

  typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY, SYNC_CHK} state_t;

  state_t              state_q;
  logic [SYNC_W-1:0]   sync_q;
  logic [HW-1:0]       hunt_cnt_q;   // hunt fill count, reused as sync-check bit index
  logic [BW-1:0]       bit_cnt_q;
  logic [DATA_W-1:0]   payload_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                data_valid_q;
  logic                locked_q;
  logic                sync_err_q;
`ifdef FRAME_PARITY_EN
  logic                parity_err_q;
`endif

  logic [SYNC_W-1:0]   sync_d;
  logic [DATA_W-1:0]   payload_d;
  logic [SYNC_W-1:0]   sync_exp_d;
  logic                exp_bit_d;
  logic                hunt_match_d;

  // Shift candidates including the current bit, plus the expected sync bit.
  always_comb begin
    sync_d       = {sync_q[SYNC_W-2:0], bit_in};
    payload_d    = {payload_q[DATA_W-2:0], bit_in};
    sync_exp_d   = SYNC_WORD << hunt_cnt_q;
    exp_bit_d    = sync_exp_d[SYNC_W-1];
    hunt_match_d = (sync_d == SYNC_WORD) && (hunt_cnt_q >= SYNC_LAST);
  end

  // Frame FSM with registered outputs; pulses self-clear every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      hunt_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      payload_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef FRAME_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef FRAME_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bit_valid) begin
        case (state_q)
          HUNT: begin
            sync_q <= sync_d;
            if (hunt_cnt_q != SYNC_FULL) hunt_cnt_q <= hunt_cnt_q + HW'(1);
            if (hunt_match_d) begin
              state_q   <= PAYLOAD;
              bit_cnt_q <= '0;
              locked_q  <= 1'b1;
            end
          end
          PAYLOAD: begin
            payload_q <= payload_d;
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              hunt_cnt_q <= '0;
`ifdef FRAME_PARITY_EN
              state_q <= PARITY;
`else
              state_q      <= SYNC_CHK;
              data_out_q   <= payload_d;
              data_valid_q <= 1'b1;
`endif
            end
          end
`ifdef FRAME_PARITY_EN
          PARITY: begin
            // Even parity: payload XOR parity bit must be zero.
            if ((^payload_q ^ bit_in) == 1'b0) begin
              data_out_q   <= payload_q;
              data_valid_q <= 1'b1;
            end else begin
              parity_err_q <= 1'b1;
            end
            state_q    <= SYNC_CHK;
            hunt_cnt_q <= '0;
          end
`endif
          SYNC_CHK: begin
            if (bit_in != exp_bit_d) begin
              // The offending bit is dropped; hunting restarts from empty.
              state_q    <= HUNT;
              sync_err_q <= 1'b1;
              locked_q   <= 1'b0;
              hunt_cnt_q <= '0;
              sync_q     <= '0;
            end else if (hunt_cnt_q == SYNC_LAST) begin
              state_q   <= PAYLOAD;
              bit_cnt_q <= '0;
            end else begin
              hunt_cnt_q <= hunt_cnt_q + HW'(1);
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
`ifdef FRAME_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_frame_deser.sv
// Randomised bench for frame_deser with a frame-level reference model.
module tb_frame_deser;

`ifdef FRAME_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int PL = PAR ? 17 : 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic [15:0] data_out;
  logic        data_valid;
  logic        locked;
  logic        sync_err;
  logic        parity_err;

  frame_deser dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .sync_err  (sync_err)
`ifdef FRAME_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

`ifndef FRAME_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: locked flag, bits seen while hunting, position in frame
  logic [7:0]  sync_pat = 8'hA5;
  bit          m_lock;
  int          m_n;
  logic [7:0]  m_hist;
  int          m_pos;
  logic [15:0] m_word;
  logic [15:0] e_do;
  logic        e_dv, e_lk, e_se, e_pe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_n = 0; m_hist = '0; m_pos = 0; m_word = '0;
    e_do = '0; e_dv = 0; e_lk = 0; e_se = 0; e_pe = 0;
  endtask

  task automatic model_bit(input logic b);
    int idx;
    e_dv = 0; e_se = 0; e_pe = 0;
    if (!m_lock) begin
      m_hist = {m_hist[6:0], b};
      m_n++;
      if (m_n >= 8 && m_hist == sync_pat) begin
        m_lock = 1;
        m_pos  = 0;
      end
    end else if (m_pos < 16) begin
      m_word = {m_word[14:0], b};
      m_pos++;
      if (m_pos == 16 && !PAR) begin
        e_dv = 1; e_do = m_word;
      end
    end else if (PAR && m_pos == 16) begin
      if (((^m_word) ^ b) == 1'b0) begin
        e_dv = 1; e_do = m_word;
      end else begin
        e_pe = 1;
      end
      m_pos++;
    end else begin
      idx = m_pos - PL;
      if (b != sync_pat[7-idx]) begin
        m_lock = 0; m_n = 0; e_se = 1;
      end else begin
        m_pos++;
        if (idx == 7) m_pos = 0;
      end
    end
    e_lk = m_lock;
  endtask

  task automatic check_outputs();
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("data_out",   32'(data_out),   32'(e_do));
    chk("locked",     32'(locked),     32'(e_lk));
    chk("sync_err",   32'(sync_err),   32'(e_se));
    if (PAR) chk("parity_err", 32'(parity_err), 32'(e_pe));
  endtask

  // called at a negedge; returns at a negedge
  task automatic send_bit(input logic b, input int gap);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    model_bit(b);
    check_outputs();
    bit_valid = 1'b0;
    bit_in = $urandom_range(0, 1);
    e_dv = 0; e_se = 0; e_pe = 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    logic [31:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) send_bit(t[i], gap);
  endtask

  // sync + payload (+ parity bit when enabled)
  task automatic send_frame(input logic [7:0] s, input logic [15:0] p, input logic pb, input int gap);
    send_bits(32'(s), 8, gap);
    send_bits(32'(p), 16, gap);
    if (PAR) send_bit(pb, gap);
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; bit_in = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  s;
    logic        pb;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    do_reset();
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_locked",   32'(locked),   32'h0);

    // basic frame
    send_frame(8'hA5, 16'h1234, ^16'h1234, 0);
    chk("basic_data", 32'(data_out), 32'h1234);
    chk("basic_lock", 32'(locked),   32'h1);

    // back-to-back, one valid bit every 16 cycles
    do_reset();
    send_frame(8'hA5, 16'h1234, ^16'h1234, 15);
    send_frame(8'hA5, 16'hBEEF, ^16'hBEEF, 15);
    send_frame(8'hA5, 16'h0001, ^16'h0001, 15);
    chk("b2b_data", 32'(data_out), 32'h0001);

    // bad sync word, then recovery
    do_reset();
    send_frame(8'hA5, 16'h1234, ^16'h1234, 0);
    send_bits(32'hA4, 8, 0);
    chk("badsync_lock", 32'(locked), 32'h0);
    send_frame(8'hA5, 16'h5555, ^16'h5555, 0);
    chk("recover_data", 32'(data_out), 32'h5555);

    // false prefix 10_1010_0101
    do_reset();
    send_bits(32'h2A5, 10, 0);
    chk("prefix_lock", 32'(locked), 32'h1);

    // reset mid-payload
    do_reset();
    send_bits(32'hA5, 8, 0);
    send_bits(32'h1234 >> 7, 9, 0);
    do_reset();
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_lock", 32'(locked),   32'h0);
    send_frame(8'hA5, 16'hABCD, ^16'hABCD, 1);
    chk("midrst_next", 32'(data_out), 32'hABCD);

    if (PAR) begin
      do_reset();
      send_frame(8'hA5, 16'h1234, ~(^16'h1234), 0);
      chk("par_bad_hold", 32'(data_out), 32'h0);
      send_frame(8'hA5, 16'h1234, ^16'h1234, 0);
      chk("par_good", 32'(data_out), 32'h1234);
    end

    // randomised frames with occasional sync corruption and noise
    do_reset();
    for (int f = 0; f < 60; f++) begin
      p  = 16'($urandom);
      s  = 8'hA5;
      pb = ^p;
      if ($urandom_range(0, 4) == 0) s = s ^ (8'h1 << $urandom_range(0, 7));
      if (PAR && $urandom_range(0, 4) == 0) pb = ~pb;
      if ($urandom_range(0, 9) == 0) send_bits(32'($urandom), $urandom_range(1, 3), 0);
      send_frame(s, p, pb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
